// File: rtl/any1_pkg.sv
// any1_pkg: shared types and defaults for the ANY-1 external bus arbiter.
//   arb_state_t    - arbiter state encoding (idle / busy / error-wait)
//   bus_req_t      - one requester's bus request bundle (179 bits packed)
//   ANY1_TMO_LIMIT - default strobe-without-ack timeout, in cycles
`timescale 1ns/1ps
package any1_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_ERRW
  } arb_state_t;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
  } bus_req_t;

  localparam int unsigned ANY1_TMO_LIMIT = 255;

endpackage

// File: rtl/any1_bus_arbiter.sv
// any1_bus_arbiter: shares the single 128-bit external bus between the
// instruction-fetch port (m0) and the load/store port (m1).
//   - round-robin grant from IDLE, ownership held for the whole cyc period
//   - one dead cycle between successive owners
//   - vpa_o marks fetch-port ownership of an active cycle
//   - bus timeout: TMO_LIMIT cycles of stb without ack return a one-cycle
//     err to the owner, then the bus stays off until the owner drops cyc
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   mN_cyc/stb/we/sel/adr/dat_i     requester N bus request (N = 0,1)
//   mN_ack_o, mN_err_o, mN_dat_o    requester N return path
//   vpa_o                           fetch port owns an active cycle
//   cyc/stb/we/sel/adr/dat_o        external bus request
//   ack_i, dat_i                    external bus response
`timescale 1ns/1ps
module any1_bus_arbiter
  import any1_pkg::*;
#(
  parameter int unsigned TMO_LIMIT = ANY1_TMO_LIMIT
) (
  input  logic         clk_i,
  input  logic         rst_i,

  input  logic         m0_cyc_i,
  input  logic         m0_stb_i,
  input  logic         m0_we_i,
  input  logic [15:0]  m0_sel_i,
  input  logic [31:0]  m0_adr_i,
  input  logic [127:0] m0_dat_i,
  output logic         m0_ack_o,
  output logic         m0_err_o,
  output logic [127:0] m0_dat_o,

  input  logic         m1_cyc_i,
  input  logic         m1_stb_i,
  input  logic         m1_we_i,
  input  logic [15:0]  m1_sel_i,
  input  logic [31:0]  m1_adr_i,
  input  logic [127:0] m1_dat_i,
  output logic         m1_ack_o,
  output logic         m1_err_o,
  output logic [127:0] m1_dat_o,

  output logic         vpa_o,
  output logic         cyc_o,
  output logic         stb_o,
  output logic         we_o,
  output logic [15:0]  sel_o,
  output logic [31:0]  adr_o,
  output logic [127:0] dat_o,
  input  logic         ack_i,
  input  logic [127:0] dat_i
);

  localparam logic [7:0] TMO_LAST = 8'(TMO_LIMIT - 1);

  arb_state_t state, state_d;
  logic       owner, owner_d;
  logic       last, last_d;
  logic [7:0] tmo, tmo_d;

  bus_req_t req0, req1, own;
  logic     busy;
  logic     tmo_hit;

  assign req0 = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
  assign req1 = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};

  always_comb begin
    own = owner ? req1 : req0;
  end

  assign busy = (state == ARB_BUSY);

  // Ack in the limit cycle suppresses the error.
  assign tmo_hit = busy & own.stb & ~ack_i & (tmo == TMO_LAST);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ARB_IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      tmo   <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      last  <= last_d;
      tmo   <= tmo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    owner_d = owner;
    last_d  = last;
    tmo_d   = tmo;
    case (state)
      ARB_IDLE: begin
        if (m0_cyc_i | m1_cyc_i) begin
          owner_d = (m0_cyc_i & m1_cyc_i) ? ~last : m1_cyc_i;
          last_d  = owner_d;
          state_d = ARB_BUSY;
          tmo_d   = '0;
        end
      end
      ARB_BUSY: begin
        if (!own.cyc) begin
          state_d = ARB_IDLE;
        end else if (ack_i || !own.stb) begin
          tmo_d = '0;
        end else if (tmo_hit) begin
          state_d = ARB_ERRW;
        end else begin
          tmo_d = tmo + 8'd1;
        end
      end
      ARB_ERRW: begin
        if (!own.cyc) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs: bus is driven only while BUSY
  always_comb begin
    cyc_o    = busy & own.cyc;
    stb_o    = busy & own.stb;
    we_o     = busy & own.we;
    sel_o    = busy ? own.sel : '0;
    adr_o    = busy ? own.adr : '0;
    dat_o    = busy ? own.dat : '0;
    vpa_o    = cyc_o & ~owner;
    m0_ack_o = ack_i & stb_o & ~owner;
    m1_ack_o = ack_i & stb_o &  owner;
    m0_err_o = tmo_hit & ~owner;
    m1_err_o = tmo_hit &  owner;
    m0_dat_o = dat_i;
    m1_dat_o = dat_i;
  end

endmodule

// File: tb/tb_any1_bus_arbiter.sv
`timescale 1ns/1ps
module tb_any1_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [15:0]  m0_sel_i = '0;
  logic [31:0]  m0_adr_i = '0;
  logic [127:0] m0_dat_i = '0;
  logic         m0_ack_o, m0_err_o;
  logic [127:0] m0_dat_o;
  logic         m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [15:0]  m1_sel_i = '0;
  logic [31:0]  m1_adr_i = '0;
  logic [127:0] m1_dat_i = '0;
  logic         m1_ack_o, m1_err_o;
  logic [127:0] m1_dat_o;
  logic         vpa_o, cyc_o, stb_o, we_o;
  logic [15:0]  sel_o;
  logic [31:0]  adr_o;
  logic [127:0] dat_o;
  logic         ack_i = 1'b0;
  logic [127:0] dat_i = '0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          port;
    logic [31:0] adr;
    logic        we;
    logic [15:0] sel;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  any1_bus_arbiter #(.TMO_LIMIT(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .vpa_o(vpa_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i), .dat_i(dat_i)
  );

  // Scoreboard: every delivered ack must match the next expected transfer.
  always @(negedge clk) begin
    if (m0_ack_o || m1_ack_o) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_ack: got m0_ack=%b m1_ack=%b adr=%h, want no ack",
                 m0_ack_o, m1_ack_o, adr_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ((m0_ack_o && m1_ack_o) || (m1_ack_o !== mon_e.port) || (adr_o !== mon_e.adr) ||
            (we_o !== mon_e.we) || (sel_o !== mon_e.sel) ||
            ((mon_e.port ? m1_dat_o : m0_dat_o) !== dat_i)) begin
          n_err++;
          $display("FAIL sb_ack: got port=%b adr=%h we=%b sel=%h rdat=%h, want port=%b adr=%h we=%b sel=%h rdat=%h",
                   m1_ack_o, adr_o, we_o, sel_o, (mon_e.port ? m1_dat_o : m0_dat_o),
                   mon_e.port, mon_e.adr, mon_e.we, mon_e.sel, dat_i);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [15:0] sel, input logic [31:0] adr);
    m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
    m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = {4{adr}};
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [15:0] sel, input logic [31:0] adr);
    m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
    m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = {4{~adr}};
  endtask

  task automatic push_exp(input bit port, input logic [31:0] adr,
                          input logic we, input logic [15:0] sel);
    exp_t e;
    e.port = port; e.adr = adr; e.we = we; e.sel = sel;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; ack_i = 1'b0; dat_i = '0;
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    nxt(); nxt();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_m0(1, 1, 1, 16'hFFFF, 32'h1234_5670);
    ack_i = 1'b1;
    for (int unsigned c = 0; c < 2; c++) begin
      nxt();
      @(negedge clk);
      n_vec++;
      if ({cyc_o, stb_o, we_o, vpa_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 8'h00) begin
        n_err++;
        $display("FAIL rst_ctrl: got %b, want 00000000",
                 {cyc_o, stb_o, we_o, vpa_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
      end
      n_vec++;
      if ({sel_o, adr_o, dat_o} !== '0) begin
        n_err++;
        $display("FAIL rst_bus: got sel=%h adr=%h dat=%h, want 0", sel_o, adr_o, dat_o);
      end
    end
    ack_i = 1'b0;
    set_m0(0, 0, 0, '0, '0);
    rst_i = 1'b0;
    nxt();
  endtask

  task automatic test_port0_alone();
    logic [127:0] rd;
    rd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    nxt();
    set_m0(1, 1, 0, 16'hFFFF, 32'hFFFC_0100);
    push_exp(0, 32'hFFFC_0100, 0, 16'hFFFF);
    @(negedge clk);
    n_vec++;
    if (cyc_o !== 1'b0) begin n_err++; $display("FAIL p0_req_cycle_cyc: got %b, want 0", cyc_o); end
    nxt();
    @(negedge clk);
    n_vec++;
    if ({cyc_o, stb_o, vpa_o} !== 3'b111 || adr_o !== 32'hFFFC_0100) begin
      n_err++;
      $display("FAIL p0_grant: got cyc/stb/vpa=%b adr=%h, want 111 fffc0100", {cyc_o, stb_o, vpa_o}, adr_o);
    end
    n_vec++;
    if (m0_ack_o !== 1'b0) begin n_err++; $display("FAIL p0_early_ack: got %b, want 0", m0_ack_o); end
    nxt();
    ack_i = 1'b1; dat_i = rd;
    @(negedge clk);
    n_vec++;
    if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || m0_dat_o !== rd) begin
      n_err++;
      $display("FAIL p0_ack: got ack0=%b ack1=%b dat=%h, want 1 0 %h", m0_ack_o, m1_ack_o, m0_dat_o, rd);
    end
    nxt();
    ack_i = 1'b0;
    set_m0(0, 0, 0, '0, '0);
    @(negedge clk);
    n_vec++;
    if (m0_ack_o !== 1'b0 || cyc_o !== 1'b0) begin
      n_err++;
      $display("FAIL p0_release: got ack=%b cyc=%b, want 0 0", m0_ack_o, cyc_o);
    end
    nxt();
    @(negedge clk);
    n_vec++;
    if (vpa_o !== 1'b0) begin n_err++; $display("FAIL p0_vpa_idle: got %b, want 0", vpa_o); end
  endtask

  task automatic test_contention();
    logic [31:0] a0, a1;
    do_reset();
    for (int unsigned r = 0; r < 2; r++) begin
      a0 = 32'h1000_0000 + 32'(r * 16);
      a1 = 32'h2000_0000 + 32'(r * 16);
      nxt();
      set_m0(1, 1, 0, 16'hFFFF, a0);
      set_m1(1, 1, 1, 16'h000F, a1);
      push_exp(0, a0, 0, 16'hFFFF);
      push_exp(1, a1, 1, 16'h000F);
      nxt();
      @(negedge clk);
      n_vec++;
      if (vpa_o !== 1'b1 || adr_o !== a0) begin
        n_err++;
        $display("FAIL cont_first_r%0d: got vpa=%b adr=%h, want 1 %h", r, vpa_o, adr_o, a0);
      end
      nxt();
      ack_i = 1'b1; dat_i = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n_vec++;
      if (m1_ack_o !== 1'b0) begin n_err++; $display("FAIL cont_nonowner_ack_r%0d: got %b, want 0", r, m1_ack_o); end
      nxt();
      ack_i = 1'b0;
      set_m0(0, 0, 0, '0, '0);
      nxt();
      @(negedge clk);
      n_vec++;
      if (cyc_o !== 1'b0) begin n_err++; $display("FAIL cont_dead_r%0d: got cyc=%b, want 0", r, cyc_o); end
      nxt();
      @(negedge clk);
      n_vec++;
      if (vpa_o !== 1'b0 || adr_o !== a1 || we_o !== 1'b1) begin
        n_err++;
        $display("FAIL cont_second_r%0d: got vpa=%b adr=%h we=%b, want 0 %h 1", r, vpa_o, adr_o, we_o, a1);
      end
      nxt();
      ack_i = 1'b1; dat_i = {$urandom, $urandom, $urandom, $urandom};
      nxt();
      ack_i = 1'b0;
      set_m1(0, 0, 0, '0, '0);
      nxt();
    end
  endtask

  task automatic test_burst_hold();
    logic [31:0] base, a;
    base = 32'h7000_0100;
    nxt();
    set_m1(1, 0, 1, 16'hFFFF, base);
    for (int unsigned i = 0; i < 4; i++) begin
      a = base + 32'(i * 16);
      nxt();
      set_m1(1, 1, 1, 16'hFFFF, a);
      if (i == 0) set_m0(1, 1, 0, 16'hFFFF, 32'hFFFC_0200);
      push_exp(1, a, 1, 16'hFFFF);
      @(negedge clk);
      if (i > 0) begin
        n_vec++;
        if (cyc_o !== 1'b1 || we_o !== 1'b1 || sel_o !== 16'hFFFF || adr_o !== a || vpa_o !== 1'b0) begin
          n_err++;
          $display("FAIL burst_beat%0d: got cyc=%b we=%b sel=%h adr=%h vpa=%b, want 1 1 ffff %h 0",
                   i, cyc_o, we_o, sel_o, adr_o, vpa_o, a);
        end
      end
      nxt();
      ack_i = 1'b1; dat_i = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n_vec++;
      if (m0_ack_o !== 1'b0) begin n_err++; $display("FAIL burst_m0_ack%0d: got %b, want 0", i, m0_ack_o); end
      nxt();
      ack_i = 1'b0;
      set_m1(1, 0, 1, 16'hFFFF, a);
      @(negedge clk);
      n_vec++;
      if (cyc_o !== 1'b1 || stb_o !== 1'b0 || vpa_o !== 1'b0) begin
        n_err++;
        $display("FAIL burst_gap%0d: got cyc=%b stb=%b vpa=%b, want 1 0 0", i, cyc_o, stb_o, vpa_o);
      end
    end
    nxt();
    set_m1(0, 0, 0, '0, '0);
    push_exp(0, 32'hFFFC_0200, 0, 16'hFFFF);
    nxt();
    @(negedge clk);
    n_vec++;
    if (cyc_o !== 1'b0) begin n_err++; $display("FAIL burst_dead: got cyc=%b, want 0", cyc_o); end
    nxt();
    @(negedge clk);
    n_vec++;
    if (vpa_o !== 1'b1 || adr_o !== 32'hFFFC_0200) begin
      n_err++;
      $display("FAIL burst_m0_grant: got vpa=%b adr=%h, want 1 fffc0200", vpa_o, adr_o);
    end
    nxt();
    ack_i = 1'b1; dat_i = {$urandom, $urandom, $urandom, $urandom};
    nxt();
    ack_i = 1'b0;
    set_m0(0, 0, 0, '0, '0);
    nxt();
  endtask

  task automatic test_timeout();
    nxt();
    set_m1(1, 1, 0, 16'h00FF, 32'h3000_0000);
    for (int unsigned k = 0; k < 8; k++) begin
      nxt();
      if (k == 2) begin
        set_m0(1, 1, 0, 16'hFFFF, 32'hFFFC_0300);
        push_exp(0, 32'hFFFC_0300, 0, 16'hFFFF);
      end
      @(negedge clk);
      n_vec++;
      if (k < 7) begin
        if (m1_err_o !== 1'b0 || stb_o !== 1'b1) begin
          n_err++;
          $display("FAIL tmo_wait%0d: got err=%b stb=%b, want 0 1", k, m1_err_o, stb_o);
        end
      end else begin
        if (m1_err_o !== 1'b1 || m0_err_o !== 1'b0 || m1_ack_o !== 1'b0) begin
          n_err++;
          $display("FAIL tmo_err: got err1=%b err0=%b ack1=%b, want 1 0 0", m1_err_o, m0_err_o, m1_ack_o);
        end
      end
    end
    nxt();
    @(negedge clk);
    n_vec++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0 || m1_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_bus_off: got cyc=%b stb=%b err=%b, want 0 0 0", cyc_o, stb_o, m1_err_o);
    end
    for (int unsigned j = 0; j < 3; j++) begin
      nxt();
      @(negedge clk);
      n_vec++;
      if (cyc_o !== 1'b0 || vpa_o !== 1'b0 || m1_err_o !== 1'b0) begin
        n_err++;
        $display("FAIL tmo_errw%0d: got cyc=%b vpa=%b err=%b, want 0 0 0", j, cyc_o, vpa_o, m1_err_o);
      end
    end
    nxt();
    set_m1(0, 0, 0, '0, '0);
    nxt();
    @(negedge clk);
    n_vec++;
    if (cyc_o !== 1'b0) begin n_err++; $display("FAIL tmo_idle: got cyc=%b, want 0", cyc_o); end
    nxt();
    @(negedge clk);
    n_vec++;
    if (vpa_o !== 1'b1 || adr_o !== 32'hFFFC_0300) begin
      n_err++;
      $display("FAIL tmo_next_grant: got vpa=%b adr=%h, want 1 fffc0300", vpa_o, adr_o);
    end
    nxt();
    ack_i = 1'b1; dat_i = {$urandom, $urandom, $urandom, $urandom};
    nxt();
    ack_i = 1'b0;
    set_m0(0, 0, 0, '0, '0);
    nxt();
  endtask

  task automatic test_ack_at_limit();
    nxt();
    set_m0(1, 1, 1, 16'hF0F0, 32'h4000_0040);
    push_exp(0, 32'h4000_0040, 1, 16'hF0F0);
    for (int unsigned k = 0; k < 8; k++) begin
      nxt();
      if (k == 7) begin
        ack_i = 1'b1; dat_i = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      n_vec++;
      if (m0_err_o !== 1'b0 || m0_ack_o !== (k == 7)) begin
        n_err++;
        $display("FAIL lim_cycle%0d: got ack=%b err=%b, want %b 0", k, m0_ack_o, m0_err_o, (k == 7));
      end
    end
    nxt();
    ack_i = 1'b0;
    set_m0(1, 0, 1, 16'hF0F0, 32'h4000_0040);
    @(negedge clk);
    n_vec++;
    if (cyc_o !== 1'b1 || m0_err_o !== 1'b0) begin
      n_err++;
      $display("FAIL lim_still_busy: got cyc=%b err=%b, want 1 0", cyc_o, m0_err_o);
    end
    nxt();
    set_m0(0, 0, 0, '0, '0);
    nxt();
  endtask

  task automatic test_reset_mid();
    nxt();
    set_m0(1, 1, 0, 16'hFFFF, 32'h5000_0000);
    nxt();
    @(negedge clk);
    n_vec++;
    if (vpa_o !== 1'b1) begin n_err++; $display("FAIL rmid_owned: got vpa=%b, want 1", vpa_o); end
    nxt();
    rst_i = 1'b1; ack_i = 1'b0; dat_i = '0;
    set_m1(1, 1, 0, 16'hFFFF, 32'h6000_0000);
    for (int unsigned c = 0; c < 2; c++) begin
      nxt();
      @(negedge clk);
      n_vec++;
      if ({cyc_o, stb_o, we_o, vpa_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 8'h00 ||
          {sel_o, adr_o, dat_o, m0_dat_o, m1_dat_o} !== '0) begin
        n_err++;
        $display("FAIL rmid_outputs%0d: got ctrl=%b adr=%h, want 00000000 0",
                 c, {cyc_o, stb_o, we_o, vpa_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, adr_o);
      end
    end
    nxt();
    rst_i = 1'b0;
    push_exp(0, 32'h5000_0000, 0, 16'hFFFF);
    push_exp(1, 32'h6000_0000, 0, 16'hFFFF);
    nxt();
    @(negedge clk);
    n_vec++;
    if (vpa_o !== 1'b1 || adr_o !== 32'h5000_0000) begin
      n_err++;
      $display("FAIL rmid_first_owner: got vpa=%b adr=%h, want 1 50000000", vpa_o, adr_o);
    end
    nxt();
    ack_i = 1'b1; dat_i = {$urandom, $urandom, $urandom, $urandom};
    nxt();
    ack_i = 1'b0;
    set_m0(0, 0, 0, '0, '0);
    nxt();
    nxt();
    @(negedge clk);
    n_vec++;
    if (adr_o !== 32'h6000_0000 || vpa_o !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_second_owner: got adr=%h vpa=%b, want 60000000 0", adr_o, vpa_o);
    end
    nxt();
    ack_i = 1'b1; dat_i = {$urandom, $urandom, $urandom, $urandom};
    nxt();
    ack_i = 1'b0;
    set_m1(0, 0, 0, '0, '0);
    nxt();
  endtask

  initial begin
    test_reset();
    test_port0_alone();
    test_contention();
    test_burst_hold();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    nxt();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending transfers, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/any1_bus_arbiter.md
# any1_bus_arbiter

Two-requester bus arbiter that shares the ANY-1 core's single 128-bit external bus between the instruction-fetch unit (port 0) and the load/store unit (port 1). It sits between the core's internal memory ports and the external bus: `cyc_o/stb_o/we_o/sel_o/adr_o/dat_o`, `ack_i/dat_i`. It provides round-robin grant, ownership held for the whole `cyc` period, `vpa_o` generation, and a bus-timeout error return.

## Interface
- `TMO_LIMIT`, default 255: cycles of `stb_o` without `ack_i` before a bus error is signalled (1..255).
- `clk_i`  in  1  core clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `m0_cyc_i, m0_stb_i, m0_we_i`  in  1 each  fetch-port cycle, strobe and write.
- `m0_sel_i`  in  16  fetch byte selects.
- `m0_adr_i`  in  32  fetch address.
- `m0_dat_i`  in  128  fetch write data.
- `m0_ack_o, m0_err_o`  out  1 each  fetch acknowledge and error.
- `m0_dat_o`  out  128  fetch read data.
- `m1_*`: identical set for the load/store port.
- `vpa_o`  out  1  valid program address; high while port 0 owns the bus and `cyc_o` is high.
- `cyc_o, stb_o, we_o`  out  1 each  external bus controls.
- `sel_o`  out  16  external byte selects.
- `adr_o`  out  32  external address.
- `dat_o`  out  128  external write data.
- `ack_i`  in  1  external acknowledge.
- `dat_i`  in  128  external read data.

## Operation
- States: `IDLE`, `BUSY`, `ERRW` (error, waiting for the requester to release).
- Registers: `state`, `owner` (1 bit), `last` (1 bit, the last port granted), `tmo` (8-bit counter).
- In `IDLE`, a port is requesting when its `mN_cyc_i` is high.
  - One port requesting: `owner` = that port.
  - Both requesting: `owner` = `~last`.
  - On any grant: `last` = `owner`, `state` = `BUSY`, `tmo` = 0.
- In `BUSY`, ownership holds while the owner's `cyc` is high. Strobe may toggle between beats (burst or RMW); the other port is never granted mid-cycle.
- Owner drops `cyc` in `BUSY`: go to `IDLE`. Re-grant happens at the earliest one cycle later; there is one dead cycle between owners.
- Bus outputs are combinational from the owner and forced low unless `state == BUSY`:
  - `cyc_o` = owner cyc.
  - `stb_o` = owner stb.
  - `we_o` = owner we.
  - `sel_o` = owner sel when `BUSY`, else 0.
  - `adr_o` and `dat_o` = owner values when `BUSY`, else 0.
- Return path:
  - `mN_ack_o` = `ack_i & stb_o & (owner == N) & BUSY`.
  - `mN_dat_o` = `dat_i` for both ports; it is only meaningful with ack.
  - Non-owner `ack` and `err` are always 0.
- Timeout:
  - In `BUSY`, `tmo` clears on `ack_i` or when `stb_o` is low, and increments when `stb_o & ~ack_i`.
  - When `tmo == TMO_LIMIT-1` and there is no ack, assert `mN_err_o` to the owner for exactly one cycle (combinational, in the cycle the count hits the limit) and go to `ERRW`.
  - In `ERRW`, all bus outputs are 0. Go to `IDLE` when the owner's `cyc` is low.
- Ack and timeout limit in the same cycle: the ack wins, and no error is signalled.
- Reset, including mid-transfer: `state` = `IDLE`, `owner` = 0, `last` = 1 (so port 0 wins the first contention), `tmo` = 0. All outputs go to 0 in the cycle following reset assertion and stay there while `rst_i` is high.

## Timing
- Grant latency: request first high in cycle N; `cyc_o`/`stb_o` high in cycle N+1.
- Ack path: `ack_i` to `mN_ack_o` is zero-cycle (combinational). `dat_i` passes straight through.
- Release: owner `cyc` low in cycle M gives `IDLE` in cycle M+1. A waiting port sees the bus in cycle M+2.
- Error timing:
  - `TMO_LIMIT` = L: `stb_o` first high in cycle S with no ack ever.
  - `err_o` is high in cycle S+L-1 only.
  - Bus outputs are low from cycle S+L.
- Throughput: with a single-cycle-ack slave (ack registered from `cyc_o`), each single-beat cycle takes 2 bus cycles plus 1 idle cycle.

## Structure
- Put in `any1_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_ERRW}`.
  - A `bus_req_t` packed struct `{cyc, stb, we, sel[15:0], adr[31:0], dat[127:0]}`.
  - Default `TMO_LIMIT` as a localparam.
- Single module. The per-port request mux is simple enough to stay inline; no sub-module.

## Test plan
- Port 0 alone: m0 requests `adr=FFFC0100`, slave acks one cycle after `cyc_o`. Expect `adr_o=FFFC0100`, `vpa_o=1`, `m0_ack_o` 1 for one cycle, `m0_dat_o=dat_i`, `m1_ack_o=0`.
- Contention after reset: both ports request in the same cycle. Expect port 0 granted first; port 1's address on `adr_o` two cycles after port 0 drops `cyc`. Repeat the contention: port 1 is *not* re-served before port 0 (order alternates 0,1,0,1).
- Burst hold: m1 keeps `cyc` high for 4 acked beats while m0 requests. Expect m0 to get no grant until m1 drops `cyc`; `we_o`/`sel_o=FFFF` follow m1 on every beat.
- Timeout: `TMO_LIMIT=8`, slave never acks. Expect `m1_err_o` high for exactly one cycle, 7 cycles after `stb_o` rises; `cyc_o=0` the next cycle; the bus stays idle until m1 drops `cyc`.
- Ack at the limit: ack arrives exactly in cycle S+L-1. Expect ack delivered and `err=0`.
- Reset mid-transfer: `rst_i` pulsed while m0 owns the bus. Expect all outputs 0 the next cycle; `state=IDLE`; the first post-reset contention is won by port 0.
